spi_reg_bridge: RTL

- SPI slave front end of the IO expander and initiator of the parallel port-register bus (en / rw / regSel / dataBus).
- Decodes SPI frames into register-bus write and read cycles that drive the 8-line port blocks.
- Returns read data on MISO.
- All SPI inputs are oversampled in the clk domain. The top level converts bus_wdata/bus_wdata_oe/bus_rdata onto the tristate dataBus.

---
 rtl/spi_reg_bridge.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that decodes command frames into parallel port-register bus cycles.
// Optional `SPI_BRIDGE_ADDR_CHECK_EN restricts regSel to the four port registers and blocks writes to 1110.
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EN_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       bus_en,
  output logic       bus_rw,
  output logic [3:0] bus_sel,
  output logic [7:0] bus_wdata,
  output logic       bus_wdata_oe,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [3:0] {
    IDLE, CMD, RD_SETUP, RD_STROBE, RD_HOLD, RD_SHIFT,
    WR_DATA, WR_SETUP, WR_STROBE, WR_HOLD, DONE
  } state_t;

  localparam logic [1:0] EN_LAST = 2'(EN_CYCLES - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise, fall, cs_fall;
  logic [4:0]             cnt;
  logic [7:0]             rx, tx;
  logic [3:0]             sel;
  logic [1:0]             ecnt;
  logic                   miso_q;
  logic                   cmd_ok, addr_ok;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev;
  assign fall    = ~sclk_s & sclk_prev;
  assign cs_fall = ~cs_s & cs_prev;
  assign busy    = (state != IDLE);
  // Gate with the raw chip select so MISO is low as soon as the master deselects.
  assign miso    = miso_q & ~cs_n;

  always_comb begin
    cmd_ok = (rx[6:4] == 3'b000);
`ifdef SPI_BRIDGE_ADDR_CHECK_EN
    addr_ok = (rx[3:0] inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) &&
              !(!rx[7] && (rx[3:0] == 4'b1110));
`else
    addr_ok = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      cnt       <= '0;
      rx        <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (cs_fall) begin
        cnt <= '0;
        rx  <= '0;
      end else if (rise && !cs_s) begin
        rx <= {rx[6:0], mosi_s};
        if (cnt != 5'd31) cnt <= cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bus_en       <= 1'b0;
      bus_rw       <= 1'b0;
      bus_sel      <= '1;
      bus_wdata    <= '0;
      bus_wdata_oe <= 1'b0;
      frame_err    <= 1'b0;
      miso_q       <= 1'b0;
      tx           <= '0;
      sel          <= '1;
      ecnt         <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          tx     <= '0;
          if (!cs_s) state <= CMD;
        end
        CMD: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (cnt == 5'd8) begin
            sel <= rx[3:0];
            if (!cmd_ok) begin
              frame_err <= 1'b1;
              state     <= DONE;
            end else if (!addr_ok) begin
              // Rejected reads still clock out a frame, returning all ones.
              frame_err <= 1'b1;
              if (rx[7]) begin
                tx    <= 8'hFF;
                state <= RD_SHIFT;
              end else begin
                state <= DONE;
              end
            end else if (rx[7]) begin
              bus_sel <= rx[3:0];
              bus_rw  <= 1'b1;
              state   <= RD_SETUP;
            end else begin
              state <= WR_DATA;
            end
          end
        end
        RD_SETUP: begin
          bus_en <= 1'b1;
          ecnt   <= '0;
          state  <= RD_STROBE;
        end
        RD_STROBE: begin
          if (ecnt == EN_LAST) begin
            bus_en <= 1'b0;
            tx     <= bus_rdata;
            state  <= RD_HOLD;
          end else begin
            ecnt <= ecnt + 2'd1;
          end
        end
        RD_HOLD: begin
          bus_sel <= '1;
          bus_rw  <= 1'b0;
          state   <= cs_s ? IDLE : RD_SHIFT;
        end
        RD_SHIFT: begin
          if (cs_s) begin
            miso_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt >= 5'd24) begin
            miso_q <= 1'b0;
            state  <= DONE;
          end else if (fall && (cnt >= 5'd16)) begin
            miso_q <= tx[7];
            tx     <= {tx[6:0], 1'b0};
          end
        end
        WR_DATA: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (cnt == 5'd16) begin
            bus_sel      <= sel;
            bus_rw       <= 1'b0;
            bus_wdata    <= rx;
            bus_wdata_oe <= 1'b1;
            state        <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          bus_en <= 1'b1;
          ecnt   <= '0;
          state  <= WR_STROBE;
        end
        WR_STROBE: begin
          if (ecnt == EN_LAST) begin
            bus_en <= 1'b0;
            state  <= WR_HOLD;
          end else begin
            ecnt <= ecnt + 2'd1;
          end
        end
        WR_HOLD: begin
          bus_sel      <= '1;
          bus_wdata_oe <= 1'b0;
          state        <= cs_s ? IDLE : DONE;
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
